// File: rtl/iitb_pkg.sv
// Shared types and constants for the IITB RISC fetch front end.
//   WORD_W       : machine word width (instructions and addresses)
//   PC_RESET_DEF : default program-counter reset value
//   fetch_state_t: fetch FSM states
//   fetch_entry_t: one buffered instruction, {pc, instr}
package iitb_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] PC_RESET_DEF = 16'h0000;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/iitb_fetch_fifo.sv
// Instruction buffer between the instruction memory and decode.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push       : write wr_data at the tail
//   pop        : retire the head entry (ignored when empty)
//   flush      : discard every entry; overrides push and pop
//   wr_data    : {pc, instr} entry to write
//   occ        : number of valid entries
//   head       : oldest entry (stale contents when occ == 0)
module iitb_fetch_fifo
    import iitb_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] PC_RESET = PC_RESET_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [2*WORD_W-1:0]          wr_data,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic [2*WORD_W-1:0]          head
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    fetch_entry_t      mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [OW-1:0]     occ_q;
    logic              pop_ok;

    assign pop_ok = pop && (occ_q != '0);
    assign occ    = occ_q;
    assign head   = mem[rd_ptr];

    // Entries are reset so that an empty buffer presents {PC_RESET, 0}.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{pc: PC_RESET, instr: '0};
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= fetch_entry_t'(wr_data);
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // The issue rule in the fetch stage guarantees a slot for every response.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && !pop_ok && (occ_q == OW'(DEPTH))));

endmodule

// File: rtl/iitb_fetch_stage.sv
// Instruction-fetch stage of the 6-stage IITB RISC pipeline.
// Owns the PC, issues reads to a synchronous instruction memory (1-cycle
// read latency), buffers returned words and hands {pc, instr} to decode.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   imem_en/imem_addr : read request and word address (= PC)
//   imem_rdata        : read data, valid the cycle after imem_en
//   redirect/_pc      : control-flow change; flushes buffered/in-flight work
//   halt_req          : stop issuing fetches
//   stall             : decode cannot accept the head this cycle
//   if_valid/if_instr/if_pc/if_pc_plus1 : instruction presented to decode
//   halted            : FSM is in HALTED
module iitb_fetch_stage
    import iitb_pkg::*;
#(
    parameter logic [15:0] PC_RESET = PC_RESET_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    input  logic        stall,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus1,
    output logic        halted
);

    localparam int OW = $clog2(DEPTH+1);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic          issue;
    logic          redir;
    logic          pop;
    logic          push;
    logic          room;
    logic [OW-1:0] occ;
    logic [OW:0]   fill;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head_entry;

    logic [15:0]   pc_p0;       // next address to fetch
    logic          vld_p1;      // a read is in flight to the memory
    logic [15:0]   tag_pc_p1;   // address of the in-flight read

    // Redirect is ignored in IDLE: nothing is buffered or in flight there.
    assign redir = redirect && (state != FS_IDLE);
    assign pop   = if_valid && !stall;
    assign push  = vld_p1 && !redir;

    // Occupancy at the end of this cycle; a new read needs a free slot then.
    assign fill = {1'b0, occ} + {{OW{1'b0}}, vld_p1} - {{OW{1'b0}}, pop};
    assign room = fill < (OW+1)'(DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            FS_IDLE: begin
                state_nxt = FS_RUN;
            end
            FS_RUN: begin
                if (redirect) begin
                    state_nxt = FS_RUN;
                end else if (halt_req) begin
                    state_nxt = FS_HALTED;
                end else begin
                    issue = room;
                end
            end
            FS_HALTED: begin
                if (redirect) begin
                    state_nxt = FS_RUN;
                end
            end
            default: begin
                state_nxt = FS_IDLE;
            end
        endcase
    end

    // p0 -> p1: issue a read and tag it with its address.
    // A redirect cycle never issues, so the in-flight slot empties itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_p0     <= PC_RESET;
            vld_p1    <= 1'b0;
            tag_pc_p1 <= PC_RESET;
        end else begin
            if (redir) begin
                pc_p0 <= redirect_pc;
            end else if (issue) begin
                pc_p0 <= pc_p0 + 16'd1;
            end
            vld_p1 <= issue;
            if (issue) begin
                tag_pc_p1 <= pc_p0;
            end
        end
    end

    // p1 -> p2: the returned word joins its tag in the buffer.
    assign wr_entry = '{pc: tag_pc_p1, instr: imem_rdata};

    iitb_fetch_fifo #(
        .DEPTH    (DEPTH),
        .PC_RESET (PC_RESET)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop && !redir),
        .flush   (redir),
        .wr_data (wr_entry),
        .occ     (occ),
        .head    (head_entry)
    );

    assign imem_en     = issue;
    assign imem_addr   = pc_p0;
    assign if_valid    = (occ != '0);
    assign if_instr    = head_entry.instr;
    assign if_pc       = head_entry.pc;
    assign if_pc_plus1 = head_entry.pc + 16'd1;
    assign halted      = (state == FS_HALTED);

endmodule

// File: tb/tb_iitb_fetch_stage.sv
module tb_iitb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic        stall;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;
    logic        halted;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] plus1;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc_cnt  = 0;
    bit   mon_en   = 1'b1;

    iitb_fetch_stage #(.PC_RESET(16'h0000), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus1 (if_pc_plus1),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word at address a holds 16'h1000 + a.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 16'h1000 + imem_addr;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_q.push_back('{pc, 16'h1000 + pc, pc + 16'd1});
    endtask

    task automatic push_lit(input logic [15:0] pc, input logic [15:0] instr, input logic [15:0] p1);
        exp_q.push_back('{pc, instr, p1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_imem_en", {15'b0, imem_en}, 16'h0000);
        check("rst_imem_addr", imem_addr, 16'h0000);
        check("rst_if_valid", {15'b0, if_valid}, 16'h0000);
        check("rst_if_instr", if_instr, 16'h0000);
        check("rst_if_pc", if_pc, 16'h0000);
        check("rst_if_pc_plus1", if_pc_plus1, 16'h0001);
        check("rst_halted", {15'b0, halted}, 16'h0000);
    endtask

    // Monitor: every instruction accepted by decode is compared in order.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !reset && if_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %h instr %h, expected nothing", if_pc, if_instr);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", if_pc, e.pc);
                check("out_instr", if_instr, e.instr);
                check("out_pc_plus1", if_pc_plus1, e.plus1);
            end
            acc_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        halt_req = 1'b0; imem_rdata = 16'h0000;
        #1 reset = 1'b1;
        tick(); tick();
        #1;
        check_reset_values();

        // Stream from reset: fetch from cycle 1, valid from cycle 3.
        reset = 1'b0;
        for (int i = 0; i < 40; i++) push_exp(16'(i));
        #1 check("idle_no_fetch", {15'b0, imem_en}, 16'h0000);
        tick();
        check("c1_en", {15'b0, imem_en}, 16'h0001);
        check("c1_addr", imem_addr, 16'h0000);
        tick();
        check("c2_addr", imem_addr, 16'h0001);
        check("c2_valid", {15'b0, if_valid}, 16'h0000);
        tick();
        check("c3_valid", {15'b0, if_valid}, 16'h0001);
        check("c3_pc", if_pc, 16'h0000);
        repeat (5) tick();

        // Stall cycles 8..12 with buffer + in-flight = 2.
        stall = 1'b1;
        #1 check("stall_en_c8", {15'b0, imem_en}, 16'h0000);
        for (int c = 9; c <= 12; c++) begin
            tick();
            check("stall_en", {15'b0, imem_en}, 16'h0000);
        end
        check("stall_head_pc", if_pc, 16'h0005);
        tick();
        stall = 1'b0;
        #1 check("resume_en", {15'b0, imem_en}, 16'h0001);
        check("resume_addr", imem_addr, 16'h0007);
        repeat (8) tick();

        // Redirect to 0x0040 with an entry buffered and a read in flight.
        check("phase1_count", 16'(acc_cnt), 16'd13);
        redirect = 1'b1; redirect_pc = 16'h0040;
        #1 check("redir_no_fetch", {15'b0, imem_en}, 16'h0000);
        exp_q.delete();
        for (int i = 0; i < 16; i++) push_exp(16'h0040 + 16'(i));
        acc_cnt = 0;
        tick();
        redirect = 1'b0;
        #1 check("redir_t1_en", {15'b0, imem_en}, 16'h0001);
        check("redir_t1_addr", imem_addr, 16'h0040);
        check("redir_t1_valid", {15'b0, if_valid}, 16'h0000);
        tick();
        check("redir_t2_valid", {15'b0, if_valid}, 16'h0000);
        tick();
        check("redir_t3_valid", {15'b0, if_valid}, 16'h0001);
        check("redir_t3_pc", if_pc, 16'h0040);
        repeat (4) tick();

        // PC wrap followed by a halt pulse.
        check("phase2_count", 16'(acc_cnt), 16'd4);
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        exp_q.delete();
        push_lit(16'hFFFE, 16'h0FFE, 16'hFFFF);
        push_lit(16'hFFFF, 16'h0FFF, 16'h0000);
        push_lit(16'h0000, 16'h1000, 16'h0001);
        push_lit(16'h0001, 16'h1001, 16'h0002);
        push_lit(16'h0002, 16'h1002, 16'h0003);
        acc_cnt = 0;
        tick();
        redirect = 1'b0;
        #1 check("wrap_addr", imem_addr, 16'hFFFE);
        repeat (5) tick();
        halt_req = 1'b1;
        #1 check("halt_no_fetch", {15'b0, imem_en}, 16'h0000);
        tick();
        halt_req = 1'b0;
        #1 check("halted_set", {15'b0, halted}, 16'h0001);
        check("halted_no_fetch", {15'b0, imem_en}, 16'h0000);
        tick();
        check("drained_valid", {15'b0, if_valid}, 16'h0000);
        check("drained_queue", 16'(exp_q.size()), 16'd0);
        check("drained_count", 16'(acc_cnt), 16'd5);
        tick(); tick();
        check("halt_hold_en", {15'b0, imem_en}, 16'h0000);
        check("halt_hold", {15'b0, halted}, 16'h0001);

        // Redirect out of HALTED.
        redirect = 1'b1; redirect_pc = 16'h0010;
        for (int i = 0; i < 4; i++) push_exp(16'h0010 + 16'(i));
        acc_cnt = 0;
        tick();
        redirect = 1'b0;
        #1 check("resume_halted", {15'b0, halted}, 16'h0000);
        check("resume_h_en", {15'b0, imem_en}, 16'h0001);
        check("resume_h_addr", imem_addr, 16'h0010);
        tick(); tick();
        check("resume_h_valid", {15'b0, if_valid}, 16'h0001);
        check("resume_h_pc", if_pc, 16'h0010);
        repeat (4) tick();
        check("phase4_count", 16'(acc_cnt), 16'd4);
        check("phase4_queue", 16'(exp_q.size()), 16'd0);

        // Asynchronous reset between clock edges with a read in flight.
        reset = 1'b1;
        exp_q.delete();
        #1 check_reset_values();
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) push_exp(16'(i));
        acc_cnt = 0;
        check("rr_idle_en", {15'b0, imem_en}, 16'h0000);
        tick();
        check("rr_c1_en", {15'b0, imem_en}, 16'h0001);
        check("rr_c1_addr", imem_addr, 16'h0000);
        check("rr_c1_valid", {15'b0, if_valid}, 16'h0000);
        tick();
        check("rr_c2_valid", {15'b0, if_valid}, 16'h0000);
        tick();
        check("rr_c3_valid", {15'b0, if_valid}, 16'h0001);
        check("rr_c3_pc", if_pc, 16'h0000);
        check("rr_c3_instr", if_instr, 16'h1000);
        repeat (6) tick();
        mon_en = 1'b0;
        check("rr_count", 16'(acc_cnt), 16'd6);
        check("rr_queue", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
